// File: rtl/acia_rx_fifo.sv
// ACIA receive buffer: edge-detected byte capture into a first-word-fall-through FIFO with sticky overrun/framing flags.
// Optional RTS hysteresis flow control is enabled by defining ACIA_RX_FIFO_RTS_EN; otherwise rts_n is tied low.
module acia_rx_fifo #(
    parameter int unsigned DEPTH_LOG2   = 4,
    parameter int unsigned RTS_HEADROOM = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_dat,
    input  logic                  rx_stb,
    input  logic                  rx_err,
    input  logic                  rd,
    input  logic                  clr,
    input  logic                  flush,
    output logic [7:0]            dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  ovr,
    output logic                  ferr,
    output logic                  rts_n
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    if (RTS_HEADROOM < 1 || RTS_HEADROOM > DEPTH / 2) begin : g_bad_headroom
        $error("acia_rx_fifo: RTS_HEADROOM out of range");
    end

    logic          stb_dly_q, stb_dly_d;
    logic          err_dly_q, err_dly_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovr_q, ovr_d;
    logic          ferr_q, ferr_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];

    logic wr_ev, err_ev, rd_ok, wr_ok;

    assign empty = (count_q == CW'(0));
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign dout  = mem_q[rptr_q];
    assign ovr   = ovr_q;
    assign ferr  = ferr_q;

    // Next-state for edge detectors, pointers, occupancy and sticky flags
    always_comb begin
        stb_dly_d = rx_stb;
        err_dly_d = rx_err;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        ovr_d     = ovr_q;
        ferr_d    = ferr_q;
        mem_d     = mem_q;

        wr_ev  = rx_stb & ~stb_dly_q;
        err_ev = rx_err & ~err_dly_q;
        rd_ok  = rd & ~empty;
        wr_ok  = wr_ev & (~full | rd_ok);

        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_ok) begin
                mem_d[wptr_q] = rx_dat;
                wptr_d        = wptr_q + PW'(1);
            end
            if (rd_ok) begin
                rptr_d = rptr_q + PW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        // Clear first so a same-cycle set event wins
        if (clr) begin
            ovr_d  = 1'b0;
            ferr_d = 1'b0;
        end
        if (wr_ev & ~wr_ok) ovr_d  = 1'b1;
        if (err_ev)         ferr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stb_dly_q <= 1'b0;
            err_dly_q <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            stb_dly_q <= stb_dly_d;
            err_dly_q <= err_dly_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            ovr_q     <= ovr_d;
            ferr_q    <= ferr_d;
        end
    end

    // Storage needs no reset: pointers and count define validity
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef ACIA_RX_FIFO_RTS_EN
    localparam logic [CW-1:0] RTS_HI = CW'(DEPTH - RTS_HEADROOM);
    localparam logic [CW-1:0] RTS_LO = CW'(DEPTH / 2);

    logic rts_n_q, rts_n_d;

    // Hysteresis: deassert near full, reassert below half
    always_comb begin
        rts_n_d = rts_n_q;
        if (count_q >= RTS_HI) begin
            rts_n_d = 1'b1;
        end else if (count_q < RTS_LO) begin
            rts_n_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rts_n_q <= 1'b0;
        end else begin
            rts_n_q <= rts_n_d;
        end
    end

    assign rts_n = rts_n_q;
`else
    assign rts_n = 1'b0;
`endif

endmodule

// File: tb/tb_acia_rx_fifo.sv
// Directed self-checking bench for acia_rx_fifo; RTS expectations follow ACIA_RX_FIFO_RTS_EN.
module tb_acia_rx_fifo;

`ifdef ACIA_RX_FIFO_RTS_EN
    localparam bit RTS_ON = 1'b1;
`else
    localparam bit RTS_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_dat;
    logic       rx_stb, rx_err, rd, clr, flush;
    logic [7:0] dout;
    logic       empty, full, ovr, ferr, rts_n;
    logic [4:0] count;

    int n_cmp = 0;
    int n_err = 0;

    acia_rx_fifo #(.DEPTH_LOG2(4), .RTS_HEADROOM(4)) dut (
        .clk(clk), .reset(reset), .rx_dat(rx_dat), .rx_stb(rx_stb), .rx_err(rx_err),
        .rd(rd), .clr(clr), .flush(flush), .dout(dout), .empty(empty), .full(full),
        .count(count), .ovr(ovr), .ferr(ferr), .rts_n(rts_n)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_dat = b;
        rx_stb = 1'b1;
        tick();
        rx_stb = 1'b0;
        tick();
    endtask

    task automatic pop();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full); end
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (ovr !== 1'b0 || ferr !== 1'b0) begin n_err++; $display("FAIL reset_flags got ovr=%b ferr=%b want 0 0", ovr, ferr); end
        n_cmp++; if (rts_n !== 1'b0) begin n_err++; $display("FAIL reset_rts got %b want 0", rts_n); end
    endtask

    task automatic test_strobe_hold();
        rx_dat = 8'h41;
        rx_stb = 1'b1;
        tick();
        n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL hold_count1 got %0d want 1", count); end
        n_cmp++; if (dout !== 8'h41) begin n_err++; $display("FAIL hold_dout got %h want 41", dout); end
        n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL hold_empty got %b want 0", empty); end
        repeat (19) tick();
        n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL hold_count20 got %0d want 1", count); end
        rx_stb = 1'b0;
        tick();
        pop();
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL hold_pop_empty got %b want 1", empty); end
    endtask

    task automatic test_fill_overrun();
        for (int i = 0; i < 16; i++) push(8'(i));
        n_cmp++; if (full !== 1'b1 || count !== 5'd16) begin n_err++; $display("FAIL fill_full got full=%b count=%0d want 1 16", full, count); end
        n_cmp++; if (ovr !== 1'b0) begin n_err++; $display("FAIL fill_ovr_pre got %b want 0", ovr); end
        n_cmp++; if (rts_n !== RTS_ON) begin n_err++; $display("FAIL fill_rts got %b want %b", rts_n, RTS_ON); end
        push(8'h10);
        n_cmp++; if (ovr !== 1'b1 || count !== 5'd16) begin n_err++; $display("FAIL fill_ovr got ovr=%b count=%0d want 1 16", ovr, count); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (dout !== 8'(i)) begin n_err++; $display("FAIL fill_pop%0d got %h want %h", i, dout, 8'(i)); end
            pop();
        end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL fill_drained got empty=%b want 1", empty); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++; if (ovr !== 1'b0) begin n_err++; $display("FAIL fill_clr got ovr=%b want 0", ovr); end
    endtask

    task automatic test_full_with_pop();
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        rx_dat = 8'h55;
        rx_stb = 1'b1;
        rd     = 1'b1;
        tick();
        rx_stb = 1'b0;
        rd     = 1'b0;
        n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL fwp_count got %0d want 16", count); end
        n_cmp++; if (ovr !== 1'b0) begin n_err++; $display("FAIL fwp_ovr got %b want 0", ovr); end
        n_cmp++; if (dout !== 8'h21) begin n_err++; $display("FAIL fwp_head got %h want 21", dout); end
        tick();
        for (int i = 1; i < 16; i++) begin
            n_cmp++; if (dout !== 8'h20 + 8'(i)) begin n_err++; $display("FAIL fwp_pop%0d got %h want %h", i, dout, 8'h20 + 8'(i)); end
            pop();
        end
        n_cmp++; if (dout !== 8'h55 || count !== 5'd1) begin n_err++; $display("FAIL fwp_last got %h count=%0d want 55 1", dout, count); end
        pop();
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL fwp_empty got %b want 1", empty); end
    endtask

    task automatic test_framing();
        rx_err = 1'b1;
        clr    = 1'b1;
        tick();
        clr    = 1'b0;
        n_cmp++; if (ferr !== 1'b1) begin n_err++; $display("FAIL ferr_set_wins got %b want 1", ferr); end
        repeat (4) tick();
        rx_err = 1'b0;
        tick();
        n_cmp++; if (ferr !== 1'b1 || count !== 5'd0) begin n_err++; $display("FAIL ferr_hold got ferr=%b count=%0d want 1 0", ferr, count); end
        pop();
        n_cmp++; if (empty !== 1'b1 || count !== 5'd0 || ferr !== 1'b1 || ovr !== 1'b0) begin
            n_err++; $display("FAIL rd_empty got empty=%b count=%0d ferr=%b ovr=%b want 1 0 1 0", empty, count, ferr, ovr);
        end
        push(8'h77);
        n_cmp++; if (dout !== 8'h77 || count !== 5'd1) begin n_err++; $display("FAIL rd_empty_ptr got %h count=%0d want 77 1", dout, count); end
        pop();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++; if (ferr !== 1'b0) begin n_err++; $display("FAIL ferr_clr got %b want 0", ferr); end
    endtask

    task automatic test_flush_reset();
        push(8'h01); push(8'h02); push(8'h03);
        n_cmp++; if (count !== 5'd3) begin n_err++; $display("FAIL flush_pre got %0d want 3", count); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (empty !== 1'b1 || count !== 5'd0) begin n_err++; $display("FAIL flush got empty=%b count=%0d want 1 0", empty, count); end
        rx_dat = 8'h99;
        rx_stb = 1'b1;
        flush  = 1'b1;
        tick();
        rx_stb = 1'b0;
        flush  = 1'b0;
        n_cmp++; if (count !== 5'd0 || ovr !== 1'b0) begin n_err++; $display("FAIL flush_wr got count=%0d ovr=%b want 0 0", count, ovr); end
        tick();
        push(8'hA1); push(8'hA2);
        rx_err = 1'b1;
        tick();
        rx_err = 1'b0;
        n_cmp++; if (count !== 5'd2 || ferr !== 1'b1 || dout !== 8'hA1) begin n_err++; $display("FAIL prereset got count=%0d ferr=%b dout=%h want 2 1 a1", count, ferr, dout); end
        do_reset();
        n_cmp++; if (empty !== 1'b1 || full !== 1'b0 || count !== 5'd0 || ovr !== 1'b0 || ferr !== 1'b0 || rts_n !== 1'b0) begin
            n_err++; $display("FAIL midreset got empty=%b full=%b count=%0d ovr=%b ferr=%b rts_n=%b want 1 0 0 0 0 0", empty, full, count, ovr, ferr, rts_n);
        end
    endtask

    task automatic test_rts();
        for (int i = 0; i < 11; i++) push(8'hC0 + 8'(i));
        n_cmp++; if (rts_n !== 1'b0) begin n_err++; $display("FAIL rts_11 got %b want 0", rts_n); end
        rx_dat = 8'hCB;
        rx_stb = 1'b1;
        tick();
        rx_stb = 1'b0;
        n_cmp++; if (count !== 5'd12 || rts_n !== 1'b0) begin n_err++; $display("FAIL rts_12_edge got count=%0d rts_n=%b want 12 0", count, rts_n); end
        tick();
        n_cmp++; if (rts_n !== RTS_ON) begin n_err++; $display("FAIL rts_12 got %b want %b", rts_n, RTS_ON); end
        repeat (4) pop();
        tick();
        n_cmp++; if (count !== 5'd8 || rts_n !== RTS_ON) begin n_err++; $display("FAIL rts_8 got count=%0d rts_n=%b want 8 %b", count, rts_n, RTS_ON); end
        pop();
        n_cmp++; if (count !== 5'd7 || rts_n !== RTS_ON) begin n_err++; $display("FAIL rts_7_edge got count=%0d rts_n=%b want 7 %b", count, rts_n, RTS_ON); end
        tick();
        n_cmp++; if (rts_n !== 1'b0) begin n_err++; $display("FAIL rts_7 got %b want 0", rts_n); end
    endtask

    initial begin
        reset  = 1'b0;
        rx_dat = 8'h00;
        rx_stb = 1'b0;
        rx_err = 1'b0;
        rd     = 1'b0;
        clr    = 1'b0;
        flush  = 1'b0;
        tick();
        test_reset();
        test_strobe_hold();
        test_fill_overrun();
        test_full_with_pop();
        test_framing();
        test_flush_reset();
        test_rts();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
